shift_sequencer: RTL

Command-driven controller for the team's 8-bit rotating shift register. That register has parallel load, rotate right, rotate left and arithmetic shift right, with a synchronous active-high reset and no hold mode. The sequencer accepts one operation per valid/ready handshake, loads the operand, issues exactly N shift cycles, then holds and presents the result until it is consumed. Between operations it keeps the register stable by reloading the register's own output every cycle.

---
 rtl/shift_sequencer.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/shift_sequencer.sv
// -----------------------------------------------------------------------------
// shift_sequencer
//
// Command-driven controller for an external WIDTH-bit rotating shift register
// that supports parallel load, rotate right, rotate left and arithmetic shift
// right. The register has a synchronous active-high reset and no hold mode.
//
// One operation is accepted per cmd valid/ready handshake. The operation:
//   1. loads the operand into the register,
//   2. issues exactly cmd_count shift cycles,
//   3. presents the result until the consumer takes it.
// Between operations the register is kept stable by reloading its own output
// every cycle.
//
// Ports
//   clock            system clock, rising edge
//   reset            asynchronous, active-low reset
//   cmd_valid        command present
//   cmd_ready        sequencer can accept a command (IDLE only)
//   cmd_op           00 rotate right, 01 rotate left, 10 ASR, 11 load only
//   cmd_data         operand
//   cmd_count        number of shift cycles
//   rsp_valid        result available
//   rsp_ready        consumer takes result
//   rsp_data         result (register output while in DONE)
//   busy             high in LOAD or SHIFT
//   sr_reset         register synchronous reset (= ~reset)
//   sr_loadn         register parallel-load enable, active low
//   sr_rotate_right  1 = shift toward bit 0, 0 = rotate toward bit WIDTH-1
//   sr_as_right      1 = MSB keeps its value on a right shift (ASR)
//   sr_data          register parallel-load data
//   sr_q             register output
// -----------------------------------------------------------------------------
module shift_sequencer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [CNT_W-1:0] cmd_count,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             busy,
  output logic             sr_reset,
  output logic             sr_loadn,
  output logic             sr_rotate_right,
  output logic             sr_as_right,
  output logic [WIDTH-1:0] sr_data,
  input  logic [WIDTH-1:0] sr_q
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    OP_ROR  = 2'b00,
    OP_ROL  = 2'b01,
    OP_ASR  = 2'b10,
    OP_LOAD = 2'b11
  } op_e;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The register clears on any clock edge while our reset is held low.
  assign sr_reset = ~reset;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its inputs regardless of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      op_q    <= OP_ROR;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    state_d         = state_q;
    op_d            = op_q;
    data_d          = data_q;
    cnt_d           = cnt_q;
    cmd_ready       = 1'b0;
    rsp_valid       = 1'b0;
    rsp_data        = '0;
    busy            = 1'b0;
    sr_loadn        = 1'b0;   // register has no hold mode: reload is "hold"
    sr_data         = sr_q;
    sr_rotate_right = 1'b0;
    sr_as_right     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          op_d    = op_e'(cmd_op);
          data_d  = cmd_data;
          cnt_d   = cmd_count;
          state_d = S_LOAD;
        end
      end

      S_LOAD: begin
        busy    = 1'b1;
        sr_data = data_q;
        if (cnt_q != CNT_ZERO && op_q != OP_LOAD) state_d = S_SHIFT;
        else                                      state_d = S_DONE;
      end

      S_SHIFT: begin
        busy     = 1'b1;
        sr_loadn = 1'b1;
        unique case (op_q)
          OP_ROR:  sr_rotate_right = 1'b1;
          OP_ROL:  sr_rotate_right = 1'b0;
          OP_ASR: begin
            sr_rotate_right = 1'b1;
            sr_as_right     = 1'b1;
          end
          default: sr_rotate_right = 1'b0;  // load-only never reaches SHIFT
        endcase
        cnt_d = cnt_q - CNT_ONE;
        // Leaving on cnt==1 makes this the last of exactly count shift edges.
        if (cnt_q == CNT_ONE) state_d = S_DONE;
      end

      S_DONE: begin
        rsp_valid = 1'b1;
        rsp_data  = sr_q;
        if (rsp_ready) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    // While reset is low the state is already IDLE, but the outputs must
    // also look inactive and the register must see load-zero.
    if (!reset) begin
      cmd_ready       = 1'b0;
      rsp_valid       = 1'b0;
      rsp_data        = '0;
      busy            = 1'b0;
      sr_loadn        = 1'b0;
      sr_data         = '0;
      sr_rotate_right = 1'b0;
      sr_as_right     = 1'b0;
    end
  end

endmodule
